// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus an iterative shift-add multiplier.
// Operands are captured on acceptance; results, flags and err are registered and held between completions.
module multicycle_alu #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   s,
    output logic [N-1:0] ALUoutput,
    output logic         Zflag,
    output logic         Cflag,
    output logic         Vflag,
    output logic         Nflag,
    output logic         err,
    output logic         out_valid
);

    localparam int LW = $clog2(N);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t         state, state_nxt;
    logic           accept, mul_last, pend;
    logic [N-1:0]   a_q, b_q;
    logic [3:0]     s_q;
    logic [2*N-1:0] acc, mcand, acc_nxt;
    logic [N-1:0]   mplier;
    logic [LW-1:0]  cnt;
    logic [N:0]     sum, dif;
    logic [LW-1:0]  sh;
    logic [N-1:0]   res;
    logic           res_c, res_v, res_e;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // in_ready is gated by rst so it reads 0 on every reset edge and rises as soon as rst drops
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mul_last  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !rst;
                if (accept && s == OP_MUL) state_nxt = S_MUL;
            end
            S_MUL: begin
                if (cnt == '0) begin
                    mul_last  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign dif     = {1'b0, a_q} + {1'b0, ~b_q} + (N+1)'(1);
    assign sh      = b_q[LW-1:0];
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        res_e = 1'b0;
        case (s_q)
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_NOR: res = ~(a_q | b_q);
            OP_ADD: begin
                res   = sum[N-1:0];
                res_c = sum[N];
                res_v = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                res   = dif[N-1:0];
                res_c = dif[N];
                res_v = (a_q[N-1] != b_q[N-1]) && (dif[N-1] != a_q[N-1]);
            end
            OP_SLT: res = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL: res = a_q << sh;
            OP_SRL: res = a_q >> sh;
            OP_SRA: res = N'($signed(a_q) >>> sh);
            default: res_e = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALUoutput <= '0;
            Zflag     <= 1'b0;
            Cflag     <= 1'b0;
            Vflag     <= 1'b0;
            Nflag     <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            pend      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (pend) begin
                ALUoutput <= res;
                Zflag     <= (res == '0);
                Cflag     <= res_c;
                Vflag     <= res_v;
                Nflag     <= res[N-1];
                err       <= res_e;
                out_valid <= 1'b1;
            end
            if (state == S_MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
                if (mul_last) begin
                    ALUoutput <= acc_nxt[N-1:0];
                    Zflag     <= (acc_nxt[N-1:0] == '0);
                    Cflag     <= |acc_nxt[2*N-1:N];
                    Vflag     <= 1'b0;
                    Nflag     <= acc_nxt[N-1];
                    err       <= 1'b0;
                    out_valid <= 1'b1;
                end
            end
            pend <= accept && (s != OP_MUL);
            if (accept) begin
                a_q <= A;
                b_q <= B;
                s_q <= s;
                if (s == OP_MUL) begin
                    acc    <= '0;
                    mcand  <= {{N{1'b0}}, A};
                    mplier <= B;
                    cnt    <= LW'(N-1);
                end
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu (N=32): directed vectors with literal expectations plus
// an arithmetic reference model compared against the outputs on every cycle.
module tb_multicycle_alu;

    localparam int N = 32;

    logic          clk, rst, in_valid, in_ready;
    logic [N-1:0]  A, B, ALUoutput;
    logic [3:0]    s;
    logic          Zflag, Cflag, Vflag, Nflag, err, out_valid;

    multicycle_alu #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .s(s), .ALUoutput(ALUoutput),
        .Zflag(Zflag), .Cflag(Cflag), .Vflag(Vflag), .Nflag(Nflag),
        .err(err), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {result, z, c, v, n, err}
    function automatic logic [36:0] model_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [63:0] wide;
        longint      sd;
        logic [31:0] r;
        logic        c, v, e;
        int          shamt;
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        shamt = int'(b[4:0]);
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                wide = {32'b0, a} + {32'b0, b};
                r = wide[31:0];
                c = wide[32];
                sd = longint'($signed(a)) + longint'($signed(b));
                v = (sd > 64'sh7FFF_FFFF) || (sd < -64'sh8000_0000);
            end
            4'b0110: begin
                r = a - b;
                c = (a >= b);
                sd = longint'($signed(a)) - longint'($signed(b));
                v = (sd > 64'sh7FFF_FFFF) || (sd < -64'sh8000_0000);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: r = a << shamt;
            4'b1001: r = a >> shamt;
            4'b1011: r = 32'($signed(a) >>> shamt);
            4'b1010: begin
                wide = {32'b0, a} * {32'b0, b};
                r = wide[31:0];
                c = (wide[63:32] != 0);
            end
            default: e = 1'b1;
        endcase
        return {r, (r == 0), c, v, r[31], e};
    endfunction

    int          cyc = 0;
    int          busy_until = 0;
    bit          live = 0;
    logic        exp_ov = 1'b0;
    logic [36:0] held = '0;
    int          due_q[$];
    logic [36:0] val_q[$];

    always @(posedge clk) begin
        bit take;
        take = !rst && in_valid && (cyc >= busy_until);
        cyc++;
        exp_ov = 1'b0;
        if (rst) begin
            due_q.delete();
            val_q.delete();
            held = '0;
            busy_until = 0;
            live = 1;
        end else begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                held = val_q[0];
                void'(due_q.pop_front());
                void'(val_q.pop_front());
                exp_ov = 1'b1;
            end
            if (take) begin
                due_q.push_back(cyc + ((s == 4'b1010) ? N : 1));
                val_q.push_back(model_op(A, B, s));
                busy_until = (s == 4'b1010) ? cyc + N : cyc;
            end
        end
    end

    always @(negedge clk) begin
        logic mready;
        if (live) begin
            mready = !rst && (cyc >= busy_until);
            chk($sformatf("cycle%0d", cyc),
                64'({out_valid, in_ready, ALUoutput, Zflag, Cflag, Vflag, Nflag, err}),
                64'({exp_ov, mready, held}));
        end
    end

    // Issue one op, then wait for its completion; flags given as {z,c,v,n,err}
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] er, input logic [4:0] ef,
                          input int elat, input int elow, input bit hold);
        int  lat, low;
        bit  found;
        @(posedge clk); #1;
        in_valid = 1'b1; A = a; B = b; s = op;
        @(posedge clk); #1;
        if (hold) begin
            A = 32'd1; B = 32'd2; s = 4'b0010;
        end else begin
            in_valid = 1'b0; A = $urandom; B = $urandom; s = 4'($urandom);
        end
        lat = 0; low = 0; found = 0;
        if (!in_ready) low++;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) found = 1;
            else if (!in_ready) low++;
        end
        in_valid = 1'b0;
        chk({name, " done"}, 64'(found), 64'd1);
        chk({name, " latency"}, 64'(lat), 64'(elat));
        chk({name, " ready_low"}, 64'(low), 64'(elow));
        chk({name, " result"}, 64'(ALUoutput), 64'(er));
        chk({name, " flags"}, 64'({Zflag, Cflag, Vflag, Nflag, err}), 64'(ef));
    endtask

    initial begin
        int pulses;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; s = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 64'({out_valid, ALUoutput, Zflag, Cflag, Vflag, Nflag, err}), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready after reset", 64'(in_ready), 64'd1);

        //     name        A             B             s        result        zcvne     lat low hold
        run_op("and",     32'd16,       32'd12,       4'b0000, 32'd0,        5'b10000, 1,  0,  0);
        run_op("or",      32'd16,       32'd12,       4'b0001, 32'd28,       5'b00000, 1,  0,  0);
        run_op("add",     32'd16,       32'd12,       4'b0010, 32'd28,       5'b00000, 1,  0,  0);
        run_op("nor",     32'd16,       32'd12,       4'b1100, 32'hFFFFFFE3, 5'b00010, 1,  0,  0);
        run_op("sub_pos", 32'd16,       32'd12,       4'b0110, 32'd4,        5'b01000, 1,  0,  0);
        run_op("sub_neg", 32'd12,       32'd16,       4'b0110, 32'hFFFFFFFC, 5'b00010, 1,  0,  0);
        run_op("add_ovf", 32'h7FFFFFFF, 32'd1,        4'b0010, 32'h80000000, 5'b00110, 1,  0,  0);
        run_op("sra",     32'h80000000, 32'd4,        4'b1011, 32'hF8000000, 5'b00010, 1,  0,  0);
        run_op("srl",     32'h80000000, 32'd4,        4'b1001, 32'h08000000, 5'b00000, 1,  0,  0);
        run_op("sll_msk", 32'd1,        32'h0000003F, 4'b1000, 32'h80000000, 5'b00010, 1,  0,  0);
        run_op("illegal", 32'd16,       32'd12,       4'b1111, 32'd0,        5'b10001, 1,  0,  0);
        run_op("mul",     32'd16,       32'd12,       4'b1010, 32'd192,      5'b00000, N,  N,  1);
        run_op("mul_hi",  32'h00010000, 32'h00010000, 4'b1010, 32'd0,        5'b11000, N,  N,  0);
        run_op("sub_c0",  32'd5,        32'd5,        4'b0110, 32'd0,        5'b11000, 1,  0,  0);

        // back-to-back ADD, SUB, SLT
        @(posedge clk); #1;
        in_valid = 1'b1; A = 32'd16; B = 32'd12; s = 4'b0010;
        @(posedge clk); #1;
        s = 4'b0110;
        @(posedge clk); #1;
        chk("b2b add", 64'({out_valid, ALUoutput}), {31'd0, 1'b1, 32'd28});
        A = 32'hFFFFFFFF; B = 32'd1; s = 4'b0111;
        @(posedge clk); #1;
        chk("b2b sub", 64'({out_valid, ALUoutput}), {31'd0, 1'b1, 32'd4});
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b slt", 64'({out_valid, ALUoutput}), {31'd0, 1'b1, 32'd1});
        @(posedge clk); #1;
        chk("b2b idle", 64'(out_valid), 64'd0);

        // reset 10 cycles into a multiply, with a request presented during reset
        @(posedge clk); #1;
        in_valid = 1'b1; A = 32'd7; B = 32'd9; s = 4'b1010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; A = 32'd3; B = 32'd4; s = 4'b0010;
        @(posedge clk); #1;
        chk("abort outputs", 64'({out_valid, ALUoutput, Zflag, Cflag, Vflag, Nflag, err}), 64'd0);
        chk("abort ready", 64'(in_ready), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("abort ready after", 64'(in_ready), 64'd1);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort no pulse", 64'(pulses), 64'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
